// File: rtl/rc4_encrypt_loop.sv
`default_nettype none
// ============================================================================
// Module   : rc4_encrypt_loop
// Function : RC4 PRGA encryption over a key-scheduled S RAM:
//            ct[k] = keystream[k] ^ pt[k]
// Revision : 1.0 - initial release
// ============================================================================

module rc4_encrypt_loop #(
  parameter int MSG_LENGTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_flag,
  output logic       done_flag,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  localparam int                  c_wait_w    = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_LATENCY);
  localparam logic [8:0]          c_msg_len   = 9'(MSG_LENGTH);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHK   = 4'd1,
    S_RD_SI = 4'd2,
    S_RD_SJ = 4'd3,
    S_WR_SJ = 4'd4,
    S_WR_SI = 4'd5,
    S_RD_F  = 4'd6,
    S_WR_CT = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t              r_state;
  logic [7:0]          r_i;
  logic [7:0]          r_j;
  logic [8:0]          r_k;
  logic [7:0]          r_si;
  logic [7:0]          r_sj;
  logic [c_wait_w-1:0] r_wait;

  logic [7:0] w_j_next;
  logic       w_wait_done;

  assign w_j_next    = r_j + s_rddata;
  assign w_wait_done = (r_wait == c_wait_last);

  // Each read state holds its address for RD_LATENCY extra cycles and
  // samples the returned data on its last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_i       <= 8'd0;
      r_j       <= 8'd0;
      r_k       <= 9'd0;
      r_si      <= 8'd0;
      r_sj      <= 8'd0;
      r_wait    <= '0;
      done_flag <= 1'b0;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_flag) begin
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 9'd0;
            done_flag <= 1'b0;
            r_state   <= S_CHK;
          end
        end

        S_CHK: begin
          if (r_k == c_msg_len) begin
            done_flag <= 1'b1;
            s_addr    <= 8'd0;
            pt_addr   <= 8'd0;
            ct_addr   <= 8'd0;
            s_wren    <= 1'b0;
            ct_wren   <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            s_addr  <= r_i + 8'd1;
            r_wait  <= '0;
            r_state <= S_RD_SI;
          end
        end

        S_RD_SI: begin
          if (w_wait_done) begin
            r_si    <= s_rddata;
            r_j     <= w_j_next;
            s_addr  <= w_j_next;
            r_wait  <= '0;
            r_state <= S_RD_SJ;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_RD_SJ: begin
          if (w_wait_done) begin
            r_sj     <= s_rddata;
            s_addr   <= r_j;
            s_wrdata <= r_si;
            s_wren   <= 1'b1;
            r_state  <= S_WR_SJ;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_WR_SJ: begin
          s_addr   <= r_i;
          s_wrdata <= r_sj;
          r_state  <= S_WR_SI;
        end

        // Keystream read is issued only after both swap writes have landed.
        S_WR_SI: begin
          s_wren  <= 1'b0;
          s_addr  <= r_si + r_sj;
          pt_addr <= r_k[7:0];
          r_wait  <= '0;
          r_state <= S_RD_F;
        end

        S_RD_F: begin
          if (w_wait_done) begin
            ct_addr   <= r_k[7:0];
            ct_wrdata <= s_rddata ^ pt_rddata;
            ct_wren   <= 1'b1;
            r_state   <= S_WR_CT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_WR_CT: begin
          ct_wren <= 1'b0;
          r_k     <= r_k + 9'd1;
          r_state <= S_CHK;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
